// File: rtl/va_ovc_state.sv
// ---------------------------------------------------------------------------
// va_ovc_state
//
// Output-VC side of VC allocation for one router output port. Each of the
// V output VCs arbitrates round-robin among all N*V input VCs, issues a
// one-cycle registered grant, tracks ownership (IDLE/ACTIVE/DRAIN) and keeps
// a downstream credit counter.
//
// Ports:
//   clk            in   rising-edge clock
//   rstn           in   asynchronous active-low reset
//   reqIn          in   [N*V*V] bit (i*V+j)*V+k : input VC (i,j) wants output VC k
//   grantOut       out  [N*V*V] same indexing, at most one bit per k, one cycle
//   flitSent       in   [V] a flit leaves on output VC k (consumes a credit)
//   tailSent       in   [V] that flit is a tail (only meaningful with flitSent)
//   creditIn       in   [V] downstream returns one credit for VC k
//   outVCAvailable out  [V] VC k is IDLE and may be requested
//   creditAvail    out  [V] credit count of VC k is nonzero
//   creditErr      out  sticky credit underflow/overflow flag
//
// Build option:
//   VA_ATOMIC_REALLOC_EN  when defined, a tail parks the VC in DRAIN until all
//                         DEPTH credits are back, so a VC is only reallocated
//                         once the downstream buffer is empty.
//
// N and V default to the router-wide values (5 ports, 4 VCs per port).
// ---------------------------------------------------------------------------
module va_ovc_state #(
  parameter int N     = 5,
  parameter int V     = 4,
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [N*V*V-1:0] reqIn,
  output logic [N*V*V-1:0] grantOut,
  input  logic [V-1:0]     flitSent,
  input  logic [V-1:0]     tailSent,
  input  logic [V-1:0]     creditIn,
  output logic [V-1:0]     outVCAvailable,
  output logic [V-1:0]     creditAvail,
  output logic             creditErr
);

  localparam int NV = N * V;
  localparam int PW = (NV > 1) ? $clog2(NV) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DRAIN  = 2'd2
  } state_e;

  state_e          r_state [V];
  logic [CW-1:0]   r_cnt   [V];
  logic [PW-1:0]   r_ptr   [V];
  logic [NV*V-1:0] r_grant;
  logic            r_err;

  state_e          w_state_nxt [V];
  logic [CW-1:0]   w_cnt_nxt   [V];
  logic [PW-1:0]   w_ptr_nxt   [V];
  logic [NV*V-1:0] w_grant_nxt;
  logic            w_err_nxt;

  logic [V-1:0][NV-1:0]   w_req;
  logic [V-1:0][2*NV-1:0] w_dbl;
  logic [V-1:0][NV-1:0]   w_rot;
  logic [V-1:0]           w_win_vld;
  logic [V-1:0]           w_grant_ok;
  logic [PW:0]            w_sum     [V];
  logic [PW-1:0]          w_win_idx [V];
  logic [V-1:0]           w_tail;

  // Round-robin arbitration: rotate the requester vector so the pointer sits
  // at bit 0, pick the lowest set bit, then rotate the offset back.
  always_comb begin
    w_req      = '0;
    w_dbl      = '0;
    w_rot      = '0;
    w_win_vld  = '0;
    w_grant_ok = '0;
    for (int k = 0; k < V; k++) begin
      w_sum[k]     = '0;
      w_win_idx[k] = '0;
      for (int r = 0; r < NV; r++) begin
        w_req[k][r] = reqIn[r*V+k];
      end
      w_dbl[k] = {w_req[k], w_req[k]};
      w_rot[k] = NV'(w_dbl[k] >> r_ptr[k]);
      // Descending scan so the lowest offset is the one that sticks.
      for (int i = NV - 1; i >= 0; i--) begin
        if (w_rot[k][i]) begin
          w_win_vld[k] = 1'b1;
          w_sum[k]     = {1'b0, r_ptr[k]} + (PW+1)'(i);
        end
      end
      if (w_sum[k] >= (PW+1)'(NV)) begin
        w_sum[k] = w_sum[k] - (PW+1)'(NV);
      end
      w_win_idx[k]  = w_sum[k][PW-1:0];
      w_grant_ok[k] = w_win_vld[k] && (r_state[k] == ST_IDLE);
    end
  end

  // Credit counters saturate at both ends; a saturated event raises the
  // sticky error instead of wrapping.
  always_comb begin
    w_err_nxt = r_err;
    for (int k = 0; k < V; k++) begin
      w_cnt_nxt[k] = r_cnt[k];
      case ({creditIn[k], flitSent[k]})
        2'b10: begin
          if (r_cnt[k] == CW'(DEPTH)) w_err_nxt = 1'b1;
          else                        w_cnt_nxt[k] = r_cnt[k] + CW'(1);
        end
        2'b01: begin
          if (r_cnt[k] == '0) w_err_nxt = 1'b1;
          else                w_cnt_nxt[k] = r_cnt[k] - CW'(1);
        end
        default: w_cnt_nxt[k] = r_cnt[k];
      endcase
    end
  end

  // Ownership FSM, grant vector and pointer update.
  always_comb begin
    w_grant_nxt = '0;
    for (int k = 0; k < V; k++) begin
      w_state_nxt[k] = r_state[k];
      w_ptr_nxt[k]   = r_ptr[k];
      w_tail[k]      = flitSent[k] & tailSent[k];

      for (int r = 0; r < NV; r++) begin
        w_grant_nxt[r*V+k] = w_grant_ok[k] && (w_win_idx[k] == PW'(r));
      end

      if (w_grant_ok[k]) begin
        w_ptr_nxt[k] = (w_win_idx[k] == PW'(NV - 1)) ? '0 : w_win_idx[k] + PW'(1);
      end

      case (r_state[k])
        ST_IDLE: begin
          // A tail seen while IDLE only consumes a credit.
          if (w_grant_ok[k]) w_state_nxt[k] = ST_ACTIVE;
        end
        ST_ACTIVE: begin
          if (w_tail[k]) begin
`ifdef VA_ATOMIC_REALLOC_EN
            // Skip DRAIN when the buffer is already empty after this edge.
            w_state_nxt[k] = (w_cnt_nxt[k] == CW'(DEPTH)) ? ST_IDLE : ST_DRAIN;
`else
            w_state_nxt[k] = ST_IDLE;
`endif
          end
        end
        ST_DRAIN: begin
`ifdef VA_ATOMIC_REALLOC_EN
          if (w_cnt_nxt[k] == CW'(DEPTH)) w_state_nxt[k] = ST_IDLE;
`else
          w_state_nxt[k] = ST_IDLE;
`endif
        end
        default: w_state_nxt[k] = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < V; k++) begin
        r_state[k] <= ST_IDLE;
        r_cnt[k]   <= CW'(DEPTH);
        r_ptr[k]   <= '0;
      end
      r_grant <= '0;
      r_err   <= 1'b0;
    end else begin
      for (int k = 0; k < V; k++) begin
        r_state[k] <= w_state_nxt[k];
        r_cnt[k]   <= w_cnt_nxt[k];
        r_ptr[k]   <= w_ptr_nxt[k];
      end
      r_grant <= w_grant_nxt;
      r_err   <= w_err_nxt;
    end
  end

  always_comb begin
    outVCAvailable = '0;
    creditAvail    = '0;
    for (int k = 0; k < V; k++) begin
      outVCAvailable[k] = (r_state[k] == ST_IDLE);
      creditAvail[k]    = (r_cnt[k] != '0);
    end
  end

  assign grantOut  = r_grant;
  assign creditErr = r_err;

endmodule

// File: tb/tb_va_ovc_state.sv
// ---------------------------------------------------------------------------
// tb_va_ovc_state
//
// Directed bench for va_ovc_state with N=5, V=4, DEPTH=4. Inputs change 1 ns
// after the rising edge; outputs are sampled at the same point, i.e. they
// show the state registered by the edge just passed.
// ---------------------------------------------------------------------------
module tb_va_ovc_state;

  localparam int N  = 5;
  localparam int V  = 4;
  localparam int NV = N * V;
  localparam int GW = NV * V;

  logic          clk = 1'b0;
  logic          rstn;
  logic [GW-1:0] reqIn;
  logic [GW-1:0] grantOut;
  logic [V-1:0]  flitSent;
  logic [V-1:0]  tailSent;
  logic [V-1:0]  creditIn;
  logic [V-1:0]  outVCAvailable;
  logic [V-1:0]  creditAvail;
  logic          creditErr;

  int n_checks = 0;
  int n_errors = 0;

  va_ovc_state #(.N(N), .V(V), .DEPTH(4), .CW(3)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .reqIn          (reqIn),
    .grantOut       (grantOut),
    .flitSent       (flitSent),
    .tailSent       (tailSent),
    .creditIn       (creditIn),
    .outVCAvailable (outVCAvailable),
    .creditAvail    (creditAvail),
    .creditErr      (creditErr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [GW-1:0] obs, input logic [GW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [GW-1:0] gbit(input int r, input int k);
    return GW'(1) << (r * V + k);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn     = 1'b0;
    reqIn    = '0;
    flitSent = '0;
    tailSent = '0;
    creditIn = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_avail",  GW'(outVCAvailable), GW'(4'b1111));
    check("rst_credit", GW'(creditAvail),    GW'(4'b1111));
    check("rst_grant",  grantOut,            '0);
    check("rst_err",    GW'(creditErr),      GW'(1'b0));
    rstn = 1'b1;
    tick();
    check("rel_avail",  GW'(outVCAvailable), GW'(4'b1111));

    // r=3 and r=7 request k=1; pointer 0 -> r=3 first, then r=7.
    reqIn = gbit(3, 1) | gbit(7, 1);
    tick();
    check("arb_r3",        grantOut,            gbit(3, 1));
    check("arb_r3_avail",  GW'(outVCAvailable), GW'(4'b1101));
    tick();
    check("arb_one_cycle", grantOut,            '0);
    flitSent = 4'b0010;
    tailSent = 4'b0010;
    tick();
    flitSent = '0;
    tailSent = '0;
    check("tail1_avail",   GW'(outVCAvailable), GW'(4'b1111));
    check("tail1_nogrant", grantOut,            '0);
    tick();
    check("arb_r7",        grantOut,            gbit(7, 1));
    check("arb_r7_avail",  GW'(outVCAvailable), GW'(4'b1101));
    reqIn    = '0;
    flitSent = 4'b0010;
    tailSent = 4'b0010;
    tick();
    flitSent = '0;
    tailSent = '0;
    check("tail2_avail",   GW'(outVCAvailable), GW'(4'b1111));

    // Pointer is now 8: r=19 is ahead of r=3.
    reqIn = gbit(3, 1) | gbit(19, 1);
    tick();
    check("arb_wrap_r19",  grantOut,            gbit(19, 1));
    reqIn    = '0;
    flitSent = 4'b0010;
    tailSent = 4'b0010;
    tick();
    flitSent = '0;
    tailSent = '0;
    check("tail3_avail",   GW'(outVCAvailable), GW'(4'b1111));
    creditIn = 4'b0010;
    repeat (3) tick();
    creditIn = '0;

    // VC0 credit exhaustion and underflow.
    flitSent = 4'b0001;
    repeat (3) tick();
    check("cr0_cnt1",      GW'(creditAvail),    GW'(4'b1111));
    tick();
    check("cr0_empty",     GW'(creditAvail),    GW'(4'b1110));
    check("cr0_noerr",     GW'(creditErr),      GW'(1'b0));
    tick();
    flitSent = '0;
    check("cr0_under_cnt", GW'(creditAvail),    GW'(4'b1110));
    check("cr0_under_err", GW'(creditErr),      GW'(1'b1));
    creditIn = 4'b0001;
    tick();
    creditIn = '0;
    check("cr0_return",    GW'(creditAvail),    GW'(4'b1111));
    check("cr0_sticky",    GW'(creditErr),      GW'(1'b1));
    creditIn = 4'b0001;
    repeat (3) tick();
    creditIn = '0;

    // VC2: bring count to 2, simultaneous send+return, then drain by two.
    flitSent = 4'b0100;
    repeat (2) tick();
    creditIn = 4'b0100;
    tick();
    creditIn = '0;
    tick();
    check("cr2_after_one", GW'(creditAvail),    GW'(4'b1111));
    tick();
    flitSent = '0;
    check("cr2_after_two", GW'(creditAvail),    GW'(4'b1011));
    creditIn = 4'b0100;
    repeat (4) tick();
    creditIn = '0;

    // VC0 allocation and release.
    reqIn = gbit(5, 0);
    tick();
    reqIn = '0;
    check("arb_r5",        grantOut,            gbit(5, 0));
    check("arb_r5_avail",  GW'(outVCAvailable), GW'(4'b1110));
    tailSent = 4'b0001;
    tick();
    tailSent = '0;
    check("tail_no_flit",  GW'(outVCAvailable), GW'(4'b1110));
    check("tail_no_cred",  GW'(creditAvail),    GW'(4'b1111));
`ifdef VA_ATOMIC_REALLOC_EN
    flitSent = 4'b0001;
    repeat (2) tick();
    tailSent = 4'b0001;
    tick();
    flitSent = '0;
    tailSent = '0;
    check("drain_enter",   GW'(outVCAvailable), GW'(4'b1110));
    creditIn = 4'b0001;
    tick();
    check("drain_cr1",     GW'(outVCAvailable), GW'(4'b1110));
    tick();
    check("drain_cr2",     GW'(outVCAvailable), GW'(4'b1110));
    tick();
    creditIn = '0;
    check("drain_exit",    GW'(outVCAvailable), GW'(4'b1111));
    reqIn = gbit(9, 0);
    tick();
    reqIn    = '0;
    check("arb_r9",        grantOut,            gbit(9, 0));
    flitSent = 4'b0001;
    tailSent = 4'b0001;
    tick();
    flitSent = '0;
    tailSent = '0;
    check("drain_again",   GW'(outVCAvailable), GW'(4'b1110));
`else
    // Tail at edge t, request already present: IDLE at t+1, grant at t+2.
    reqIn    = gbit(9, 0);
    flitSent = 4'b0001;
    tailSent = 4'b0001;
    tick();
    flitSent = '0;
    tailSent = '0;
    check("tail0_avail",   GW'(outVCAvailable), GW'(4'b1111));
    check("tail0_nogrant", grantOut,            '0);
    tick();
    reqIn = '0;
    check("arb_r9",        grantOut,            gbit(9, 0));
    check("arb_r9_avail",  GW'(outVCAvailable), GW'(4'b1110));
`endif

    // Asynchronous reset while VC0 is owned: everything back immediately.
    #2;
    rstn = 1'b0;
    #1;
    check("arst_avail",    GW'(outVCAvailable), GW'(4'b1111));
    check("arst_credit",   GW'(creditAvail),    GW'(4'b1111));
    check("arst_grant",    grantOut,            '0);
    check("arst_err",      GW'(creditErr),      GW'(1'b0));
    @(negedge clk);
    rstn = 1'b1;
    tick();
    // Count must be back at DEPTH: a returned credit overflows.
    creditIn = 4'b0001;
    tick();
    creditIn = '0;
    check("over_err",      GW'(creditErr),      GW'(1'b1));
    check("over_credit",   GW'(creditAvail),    GW'(4'b1111));
    check("over_avail",    GW'(outVCAvailable), GW'(4'b1111));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/va_ovc_state.md
Name: va_ovc_state

Overview:
- Output-VC end of the VC allocation protocol for one router output port.
- Receives the per-input-VC request vectors produced by the input-VC allocation stage and arbitrates each output VC among all N*V input VCs.
- Issues registered grants and tracks each output VC's ownership and downstream credit state.
- Drives the outVCAvailable_Px flags that the input-VC stage uses to mask its requests.
- One instance per output port.

Parameters:
- N, `N from params.vh (5): number of router ports.
- V, `V from params.vh (4): VCs per port.
- DEPTH, 4: downstream input buffer depth per VC, in flits. This is the credit ceiling.
- CW, 3: credit counter width. Must satisfy 2^CW > DEPTH.

Ports:
- clk  input  1  clock, rising edge.
- rstn  input  1  asynchronous active-low reset.
- reqIn  input  N*V*V  reqIn[(i*V+j)*V+k]: input port i, VC j requests this port's output VC k.
- grantOut  output  N*V*V  same indexing as reqIn; at most one bit set per k.
- flitSent  input  V  a flit departs on output VC k this cycle. Consumes one credit.
- tailSent  input  V  the departing flit on VC k is a tail. Qualified only together with flitSent[k].
- creditIn  input  V  downstream returns one credit for VC k.
- outVCAvailable  output  V  VC k may be requested.
- creditAvail  output  V  credit count of VC k is nonzero (for switch allocation).
- creditErr  output  1  sticky protocol-error flag.

Behaviour:
- Reset, asynchronous, rstn low:
  - every VC state = IDLE; every credit count = DEPTH; every round-robin pointer = 0.
  - grantOut = 0; outVCAvailable = all ones; creditAvail = all ones; creditErr = 0.
  - Reset asserted mid-packet drops ownership immediately. No drain.
- Per output VC k, state machine:
  - IDLE -> ACTIVE on a grant.
  - ACTIVE -> IDLE on flitSent[k] & tailSent[k] (default build).
  - DRAIN is used only with the optional feature.
- outVCAvailable[k] = (state==IDLE), taken from registered state only.
- Arbitration, per k:
  - Requesters are the N*V bits reqIn[(r)*V+k], r = i*V+j.
  - Round-robin, starting at pointer p_k.
  - Evaluated only when state==IDLE.
  - The winner r is registered into grantOut[(r)*V+k] for exactly one cycle. Latency: request at cycle t -> grant at t+1.
  - At the same edge, state becomes ACTIVE and p_k becomes (r+1) mod N*V.
  - No requests, or state not IDLE: no grant, pointer holds.
- One input VC requesting two output VCs in the same cycle may receive both grants. Prevention is the upstream stage's responsibility, so this block does not check it.
- Credit counter, per k:
  - next = count + creditIn[k] - flitSent[k].
  - Both asserted in the same cycle: count unchanged.
  - flitSent at count 0: count stays 0 and creditErr is set.
  - creditIn at count DEPTH: count stays DEPTH and creditErr is set.
  - creditErr clears only on reset.
- creditAvail[k] = (count != 0), registered-state based.
- Tail timing:
  - tailSent with flitSent while IDLE: credit consumed, state unchanged.
  - Default build: tail at edge t gives IDLE/available at t+1. The earliest new grant is at t+2.
- tailSent without flitSent is ignored.

Optional Feature:
- Macro VA_ATOMIC_REALLOC_EN.
- When defined:
  - a tail moves ACTIVE -> DRAIN, not IDLE.
  - DRAIN -> IDLE when the credit count equals DEPTH, evaluated on the registered count including a credit arriving that cycle.
  - outVCAvailable stays low throughout DRAIN.
  - Tail with count already DEPTH (e.g. a single-flit packet whose credit returns in the same cycle): ACTIVE -> IDLE directly.
- When undefined: DRAIN is unreachable and reallocation is non-atomic, as described in Behaviour.

Test Plan:
- Reset release -> outVCAvailable=4'b1111, creditAvail=4'b1111, grantOut=0, credit counts 4.
- Input VCs r=3 and r=7 both request k=1 at cycle 5 -> grantOut[3*4+1]=1 at cycle 6 only; outVCAvailable[1]=0. A new tail-release cycle lets r=7 win at the next grant.
- Four flitSent[0] pulses with no credits -> creditAvail[0]=0. A fifth pulse -> count stays 0 and creditErr=1 (sticky). One creditIn[0] -> creditAvail[0]=1.
- flitSent[2] and creditIn[2] in the same cycle, count at 2 -> count stays 2.
- Default build: tail on VC0 at cycle 10 -> outVCAvailable[0]=1 at cycle 11; a request at cycle 11 is granted at cycle 12.
- VA_ATOMIC_REALLOC_EN: tail on VC0 with count 1 -> DRAIN, outVCAvailable[0]=0 until the third creditIn, then 1 the following cycle. rstn pulse during DRAIN -> IDLE and count 4 immediately.
